// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data memory between the core's memory
//   port (c_*) and an external loader/debug port (e_*). One access is in
//   flight at a time: an address/write cycle, a fixed read-latency wait, then
//   read-data capture and return to the requester.
//
// Ports
//   clk, res                 clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata  core request, held until c_gnt
//   c_gnt, c_rvalid, c_rdata   core grant pulse, read-data pulse, read data
//   e_*                        same set for the external port
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobes, high only in ACCESS
//   mem_rdata                  memory read data, READ_LAT cycles after mem_en
//   busy                       high whenever the arbiter is not IDLE
//
// Build option
//   ARB_RR_EN  defined: ties alternate using a last-grant pointer (core wins
//              the first tie after reset). Undefined: e always beats c.
//
// All outputs come straight from flops.

module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int READ_LAT = 2
) (
  input  logic          clk,
  input  logic          res,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_gnt,
  output logic          e_rvalid,
  output logic [DW-1:0] e_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // state    | meaning
  // ---------+-----------------------------------------------------------
  // IDLE     | waiting for a request; arbitrates and issues the access
  // ACCESS   | mem_en high; writes finish here, reads start the wait
  // RD_WAIT  | counting down the remaining read latency
  // CAPTURE  | mem_rdata valid; latched into the winner's rdata
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  // ACCESS itself covers the first latency cycle, so RD_WAIT runs READ_LAT-1.
  localparam logic [1:0] CNT_LOAD = 2'(READ_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          win_e_q, win_e_d;
  logic          c_gnt_q, c_gnt_d;
  logic          e_gnt_q, e_gnt_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          e_rvalid_q, e_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] e_rdata_q, e_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;

  logic pick_e;

`ifdef ARB_RR_EN
  // last_c_q = 1 when the core got the most recent grant; reset value 0
  // means "e was last", so the core wins the first tie.
  logic last_c_q, last_c_d;

  always_comb begin
    pick_e = e_req & (~c_req | last_c_q);
  end

  always_comb begin
    last_c_d = last_c_q;
    if (state_q == ST_IDLE && (c_req || e_req)) begin
      last_c_d = ~pick_e;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      last_c_q <= 1'b0;
    end else begin
      last_c_q <= last_c_d;
    end
  end
`else
  always_comb begin
    pick_e = e_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_e_d     = win_e_q;
    c_gnt_d     = 1'b0;
    e_gnt_d     = 1'b0;
    c_rvalid_d  = 1'b0;
    e_rvalid_d  = 1'b0;
    c_rdata_d   = c_rdata_q;
    e_rdata_d   = e_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (c_req || e_req) begin
          win_e_d     = pick_e;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_e ? e_we : c_we;
          mem_addr_d  = pick_e ? e_addr : c_addr;
          mem_wdata_d = pick_e ? e_wdata : c_wdata;
          c_gnt_d     = ~pick_e;
          e_gnt_d     = pick_e;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_we_q) begin
          state_d = ST_IDLE;
        end else if (READ_LAT == 1) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (win_e_q) begin
          e_rdata_d  = mem_rdata;
          e_rvalid_d = 1'b1;
        end else begin
          c_rdata_d  = mem_rdata;
          c_rvalid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_e_q     <= 1'b0;
      c_gnt_q     <= 1'b0;
      e_gnt_q     <= 1'b0;
      c_rvalid_q  <= 1'b0;
      e_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      e_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_e_q     <= win_e_d;
      c_gnt_q     <= c_gnt_d;
      e_gnt_q     <= e_gnt_d;
      c_rvalid_q  <= c_rvalid_d;
      e_rvalid_q  <= e_rvalid_d;
      c_rdata_q   <= c_rdata_d;
      e_rdata_q   <= e_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign c_gnt     = c_gnt_q;
  assign e_gnt     = e_gnt_q;
  assign c_rvalid  = c_rvalid_q;
  assign e_rvalid  = e_rvalid_q;
  assign c_rdata   = c_rdata_q;
  assign e_rdata   = e_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances run in lockstep on shared
// request inputs with READ_LAT = 2, 1 and 4; each has its own memory model
// that returns mem_f(addr) exactly READ_LAT cycles after a read strobe and
// junk otherwise. Read results are queued per instance when a request is
// driven and popped when rvalid appears.
module tb_mem_port_arbiter;
  localparam int NI   = 3;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LAT2 = 4;
  localparam int KMAX = 7;

  typedef struct packed {
    logic        port;   // 1 = e, 0 = c
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic        c_req, c_we, e_req, e_we;
  logic [7:0]  c_addr, e_addr;
  logic [31:0] c_wdata, e_wdata;

  logic [NI-1:0] c_gnt, c_rvalid, e_gnt, e_rvalid, mem_en, mem_we, busy;
  logic [31:0]   c_rdata [NI];
  logic [31:0]   e_rdata [NI];
  logic [31:0]   mem_wdata [NI];
  logic [7:0]    mem_addr [NI];

  exp_t        exp_q [NI][$];
  logic [31:0] last_c [NI];
  logic [31:0] last_e [NI];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_f(input logic [7:0] a);
    return 32'hDEADBEEF ^ {24'h0, a ^ 8'h10};
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return LAT0;
      1:       return LAT1;
      default: return LAT2;
    endcase
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int L = (gi == 0) ? LAT0 : (gi == 1) ? LAT1 : LAT2;
    logic [3:0]  vld_p;
    logic [7:0]  addr_p [4];
    logic [31:0] rdata_w;

    always @(posedge clk or negedge res) begin
      if (!res) vld_p <= '0;
      else      vld_p <= {vld_p[2:0], mem_en[gi] & ~mem_we[gi]};
    end
    always @(posedge clk) begin
      addr_p[0] <= mem_addr[gi];
      for (int s = 1; s < 4; s++) addr_p[s] <= addr_p[s-1];
    end
    assign rdata_w = vld_p[L-1] ? mem_f(addr_p[L-1]) : 32'hBAD0BAD0;

    mem_port_arbiter #(.AW(8), .DW(32), .READ_LAT(L)) u_dut (
      .clk(clk), .res(res),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt[gi]), .c_rvalid(c_rvalid[gi]), .c_rdata(c_rdata[gi]),
      .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
      .e_gnt(e_gnt[gi]), .e_rvalid(e_rvalid[gi]), .e_rdata(e_rdata[gi]),
      .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]), .mem_rdata(rdata_w), .busy(busy[gi])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic all_zero(input int i);
    return ({c_gnt[i], e_gnt[i], c_rvalid[i], e_rvalid[i], mem_en[i], mem_we[i], busy[i]} == 7'b0)
        && (c_rdata[i] == 32'h0) && (e_rdata[i] == 32'h0)
        && (mem_addr[i] == 8'h0) && (mem_wdata[i] == 32'h0);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      last_c[i] = '0;
      last_e[i] = '0;
    end
  endtask

  task automatic apply_reset();
    res = 1'b0; c_req = 1'b0; e_req = 1'b0;
    tick(); tick();
    res = 1'b1;
    clear_model();
    tick();
  endtask

  // Pops the scoreboard when rvalid shows up and checks rdata hold/update.
  task automatic check_rdata(input int i, input int k, input string name);
    exp_t ex;
    if (c_rvalid[i] || e_rvalid[i]) begin
      n_tests++;
      if (exp_q[i].size() == 0) begin
        n_fail++;
        $display("FAIL %s inst%0d k=%0d unexpected rvalid c=%b e=%b", name, i, k, c_rvalid[i], e_rvalid[i]);
      end else begin
        ex = exp_q[i].pop_front();
        if ((ex.port ? e_rdata[i] : c_rdata[i]) !== ex.data || {c_rvalid[i], e_rvalid[i]} !== {~ex.port, ex.port}) begin
          n_fail++;
          $display("FAIL %s inst%0d k=%0d rdata got c=%h e=%h rv=%b%b exp port=%b data=%h",
                   name, i, k, c_rdata[i], e_rdata[i], c_rvalid[i], e_rvalid[i], ex.port, ex.data);
        end
        if (ex.port) last_e[i] = ex.data;
        else         last_c[i] = ex.data;
      end
    end
    n_tests++;
    if (c_rdata[i] !== last_c[i] || e_rdata[i] !== last_e[i]) begin
      n_fail++;
      $display("FAIL %s inst%0d k=%0d rdata hold got c=%h e=%h exp c=%h e=%h",
               name, i, k, c_rdata[i], e_rdata[i], last_c[i], last_e[i]);
    end
  endtask

  task automatic test_reset();
    res = 1'b0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    clear_model();
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (all_zero(i) !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state inst%0d got gnt=%b%b rv=%b%b en=%b we=%b busy=%b", i,
                 c_gnt[i], e_gnt[i], c_rvalid[i], e_rvalid[i], mem_en[i], mem_we[i], busy[i]);
      end
    end
    res = 1'b1;
    tick();
  endtask

  task automatic do_single(input logic port, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata, input string name);
    if (!we) for (int i = 0; i < NI; i++) exp_q[i].push_back({port, mem_f(addr)});
    if (port) begin e_req = 1; e_we = we; e_addr = addr; e_wdata = wdata; end
    else      begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
    tick();
    for (int k = 1; k <= KMAX; k++) begin
      for (int i = 0; i < NI; i++) begin
        int   L;
        logic xg, xrv, xbusy;
        L     = lat_of(i);
        xg    = (k == 1);
        xrv   = !we && (k == L + 2);
        xbusy = we ? (k == 1) : (k <= L + 1);
        n_tests++;
        if ({c_gnt[i], e_gnt[i]} !== {xg & ~port, xg & port}) begin
          n_fail++;
          $display("FAIL %s inst%0d k=%0d gnt got %b%b exp %b%b", name, i, k, c_gnt[i], e_gnt[i], xg & ~port, xg & port);
        end
        n_tests++;
        if ({mem_en[i], mem_we[i]} !== {xg, xg & we}) begin
          n_fail++;
          $display("FAIL %s inst%0d k=%0d en/we got %b%b exp %b%b", name, i, k, mem_en[i], mem_we[i], xg, xg & we);
        end
        n_tests++;
        if (busy[i] !== xbusy) begin
          n_fail++;
          $display("FAIL %s inst%0d k=%0d busy got %b exp %b", name, i, k, busy[i], xbusy);
        end
        n_tests++;
        if ({c_rvalid[i], e_rvalid[i]} !== {xrv & ~port, xrv & port}) begin
          n_fail++;
          $display("FAIL %s inst%0d k=%0d rvalid got %b%b exp %b%b", name, i, k, c_rvalid[i], e_rvalid[i], xrv & ~port, xrv & port);
        end
        n_tests++;
        if (mem_addr[i] !== addr) begin
          n_fail++;
          $display("FAIL %s inst%0d k=%0d mem_addr got %h exp %h", name, i, k, mem_addr[i], addr);
        end
        if (k == 1 && we) begin
          n_tests++;
          if (mem_wdata[i] !== wdata) begin
            n_fail++;
            $display("FAIL %s inst%0d mem_wdata got %h exp %h", name, i, mem_wdata[i], wdata);
          end
        end
        check_rdata(i, k, name);
      end
      if (k == 1) begin c_req = 0; e_req = 0; end
      tick();
    end
  endtask

  // Write from e, then a core read presented while the write is in ACCESS:
  // it is ignored there and sampled in the following IDLE cycle.
  task automatic test_back_to_back();
    for (int i = 0; i < NI; i++) exp_q[i].push_back({1'b0, mem_f(8'h27)});
    e_req = 1; e_we = 1; e_addr = 8'h06; e_wdata = 32'hA5A5_5A5A;
    tick();
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < NI; i++) begin
        int   L;
        logic xbusy;
        L     = lat_of(i);
        xbusy = (k == 1) || (k >= 3 && k <= L + 3);
        n_tests++;
        if ({c_gnt[i], e_gnt[i], mem_en[i], mem_we[i]} !== {k == 3, k == 1, k == 1 || k == 3, k == 1}) begin
          n_fail++;
          $display("FAIL b2b inst%0d k=%0d gnt/en/we got %b%b%b%b", i, k, c_gnt[i], e_gnt[i], mem_en[i], mem_we[i]);
        end
        n_tests++;
        if (busy[i] !== xbusy || {c_rvalid[i], e_rvalid[i]} !== {k == L + 4, 1'b0}) begin
          n_fail++;
          $display("FAIL b2b inst%0d k=%0d busy/rvalid got %b %b%b exp %b %b0", i, k, busy[i], c_rvalid[i], e_rvalid[i], xbusy, k == L + 4);
        end
        check_rdata(i, k, "b2b");
      end
      if (k == 1) begin e_req = 0; c_req = 1; c_we = 0; c_addr = 8'h27; end
      if (k == 3) c_req = 0;
      tick();
    end
  endtask

  // Both ports request reads; four grants per instance are checked.
  task automatic test_contention();
    logic win_exp [4];
`ifdef ARB_RR_EN
    win_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    win_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
    apply_reset();
    for (int i = 0; i < NI; i++)
      for (int n = 0; n < 4; n++)
        exp_q[i].push_back({win_exp[n], mem_f(win_exp[n] ? 8'h32 : 8'h21)});
    c_req = 1; c_we = 0; c_addr = 8'h21;
    e_req = 1; e_we = 0; e_addr = 8'h32;
    tick();
    for (int k = 1; k <= 24; k++) begin
      for (int i = 0; i < NI; i++) begin
        int   L, P, n, ph;
        logic w, xg, xrv;
        L = lat_of(i);
        P = L + 2;
        if (k <= 4 * P) begin
          n   = (k - 1) / P;
          ph  = (k - 1) % P;
          w   = win_exp[n];
          xg  = (ph == 0);
          xrv = (ph == P - 1);
          n_tests++;
          if ({c_gnt[i], e_gnt[i]} !== {xg & ~w, xg & w}) begin
            n_fail++;
            $display("FAIL contention inst%0d k=%0d gnt got %b%b exp %b%b", i, k, c_gnt[i], e_gnt[i], xg & ~w, xg & w);
          end
          n_tests++;
          if ({c_rvalid[i], e_rvalid[i]} !== {xrv & ~w, xrv & w} || busy[i] !== !xrv) begin
            n_fail++;
            $display("FAIL contention inst%0d k=%0d rvalid/busy got %b%b %b exp %b%b %b", i, k,
                     c_rvalid[i], e_rvalid[i], busy[i], xrv & ~w, xrv & w, !xrv);
          end
          if (xg) begin
            n_tests++;
            if (mem_en[i] !== 1'b1 || mem_addr[i] !== (w ? 8'h32 : 8'h21)) begin
              n_fail++;
              $display("FAIL contention inst%0d k=%0d mem_en/addr got %b %h", i, k, mem_en[i], mem_addr[i]);
            end
          end
          check_rdata(i, k, "contention");
        end
      end
`ifndef ARB_RR_EN
      if (k == 1) e_req = 0;
`endif
      tick();
    end
    c_req = 0; e_req = 0;
    apply_reset();
  endtask

  task automatic test_reset_midop();
    c_req = 1; c_we = 0; c_addr = 8'h44;
    tick();
    c_req = 0;
    tick();
    #2;
    res = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (all_zero(i) !== 1'b1) begin
        n_fail++;
        $display("FAIL midop_reset inst%0d outputs not cleared busy=%b rdata c=%h e=%h", i, busy[i], c_rdata[i], e_rdata[i]);
      end
    end
    tick(); tick();
    res = 1'b1;
    clear_model();
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if ({c_rvalid[i], e_rvalid[i], c_gnt[i], e_gnt[i], busy[i]} !== 5'b0) begin
          n_fail++;
          $display("FAIL midop_quiet inst%0d k=%0d got rv=%b%b gnt=%b%b busy=%b", i, k,
                   c_rvalid[i], e_rvalid[i], c_gnt[i], e_gnt[i], busy[i]);
        end
      end
      tick();
    end
    do_single(1'b0, 1'b0, 8'h10, 32'h0, "post_reset_read");
  endtask

  initial begin
    test_reset();
    do_single(1'b0, 1'b0, 8'h10, 32'h0, "c_read");
    do_single(1'b1, 1'b1, 8'h05, 32'h1234_5678, "e_write");
    do_single(1'b1, 1'b0, 8'h33, 32'h0, "e_read");
    do_single(1'b0, 1'b1, 8'h7F, 32'hCAFE_F00D, "c_write");
    test_back_to_back();
    test_contention();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
